// File: rtl/output_port_arbiter.sv
// Output-port arbiter for a 5-port router. Round-robin grant among the
// local, N, E, S and W inputs. The grant is held for a whole packet, with
// a forced release after MAX_FLITS transfers.
module output_port_arbiter #(
  parameter int LOCK_PKT  = 1,
  parameter int MAX_FLITS = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] req,
  input  logic [4:0] tail,
  input  logic       out_ready,
  output logic [4:0] grant,
  output logic [2:0] sel,
  output logic       out_valid,
  output logic       busy,
  output logic       err
);

  typedef enum logic {IDLE, LOCKED} state_t;

  localparam logic [7:0] CNT_LAST = 8'(MAX_FLITS - 1);
  localparam logic [2:0] SEL_IDLE = 3'b111;

  state_t     state;
  logic [2:0] owner;
  logic [2:0] ptr;
  logic [7:0] cnt;

  logic       pick_vld;
  logic [2:0] pick;
  logic [2:0] idx;
  logic       xfer;
  logic       at_limit;
  logic       release_now;
  logic       forced;

  // Port index successor, wrapping 4 -> 0.
  function automatic logic [2:0] next_idx(input logic [2:0] a);
    return (a == 3'd4) ? 3'd0 : a + 3'd1;
  endfunction

  // Scan from ptr+1 around the ring; the first requester wins.
  always_comb begin
    pick_vld = 1'b0;
    pick     = 3'd0;
    idx      = ptr;
    for (int k = 0; k < 5; k++) begin
      idx = next_idx(idx);
      if (!pick_vld && req[idx]) begin
        pick_vld = 1'b1;
        pick     = idx;
      end
    end
  end

  // Flit transfer and release decision for the current owner.
  always_comb begin
    out_valid   = (state == LOCKED) && req[owner];
    xfer        = out_valid && out_ready;
    at_limit    = (cnt == CNT_LAST);
    release_now = xfer && (tail[owner] || (LOCK_PKT == 0) || at_limit);
    forced      = xfer && !tail[owner] && (LOCK_PKT != 0) && at_limit;
  end

  // Arbitration FSM. The grant, sel, busy and err outputs are registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      owner <= 3'd0;
      ptr   <= 3'd4;
      cnt   <= 8'd0;
      grant <= 5'b0;
      sel   <= SEL_IDLE;
      busy  <= 1'b0;
      err   <= 1'b0;
    end else begin
      err <= 1'b0;
      case (state)
        IDLE: begin
          if (pick_vld) begin
            state <= LOCKED;
            owner <= pick;
            cnt   <= 8'd0;
            grant <= 5'b00001 << pick;
            sel   <= pick;
            busy  <= 1'b1;
          end
        end
        LOCKED: begin
          if (release_now) begin
            // Releasing through IDLE gives the required one-cycle bubble.
            state <= IDLE;
            ptr   <= owner;
            grant <= 5'b0;
            sel   <= SEL_IDLE;
            busy  <= 1'b0;
            err   <= forced;
          end else if (xfer) begin
            cnt <= cnt + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_output_port_arbiter.sv
// Directed bench for output_port_arbiter. The model tracks the owner and
// pointer as plain integers and is checked against the DUT on every cycle.
// Literal expectations at key points pin the model itself.
module tb_output_port_arbiter;

  localparam int M = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] req;
  logic [4:0] tail;
  logic       out_ready;
  logic [4:0] grant;
  logic [2:0] sel;
  logic       out_valid;
  logic       busy;
  logic       err;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  output_port_arbiter #(.LOCK_PKT(1), .MAX_FLITS(M)) dut (
    .clk(clk), .rst(rst), .req(req), .tail(tail), .out_ready(out_ready),
    .grant(grant), .sel(sel), .out_valid(out_valid), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  // Model state: owner -1 means idle.
  int m_own = -1;
  int m_ptr = 4;
  int m_cnt = 0;
  bit m_err = 1'b0;

  // Behavioural model, advanced on every rising edge.
  always @(posedge clk) begin
    if (rst) begin
      m_own = -1; m_ptr = 4; m_cnt = 0; m_err = 1'b0;
    end else begin
      m_err = 1'b0;
      if (m_own < 0) begin
        for (int k = 1; k <= 5; k++) begin
          if (m_own < 0 && req[(m_ptr + k) % 5]) begin
            m_own = (m_ptr + k) % 5;
            m_cnt = 0;
          end
        end
      end else if (req[m_own] && out_ready) begin
        if (tail[m_own] || m_cnt == M - 1) begin
          m_err = !tail[m_own];
          m_ptr = m_own;
          m_own = -1;
        end else begin
          m_cnt++;
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Continuous comparison of every output against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("grant", 32'(grant), (m_own < 0) ? 32'd0 : 32'(1 << m_own));
      chk("sel", 32'(sel), (m_own < 0) ? 32'd7 : 32'(m_own));
      chk("busy", 32'(busy), 32'(m_own >= 0));
      chk("out_valid", 32'(out_valid), 32'((m_own >= 0) && req[m_own]));
      chk("err", 32'(err), 32'(m_err));
    end
  end

  // Apply inputs for one cycle; return just after the next rising edge.
  task automatic cyc(input logic [4:0] r, input logic [4:0] t, input logic rd);
    req = r; tail = t; out_ready = rd;
    @(posedge clk);
    #1;
  endtask

  int order [6];
  int n;

  initial begin
    rst = 1'b1; req = '0; tail = '0; out_ready = 1'b1;
    cyc(5'b0, 5'b0, 1'b1);
    chk_en = 1'b1;
    cyc(5'b0, 5'b0, 1'b1);
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_sel", 32'(sel), 32'd7);
    chk("rst_busy_err", 32'({busy, err}), 32'd0);
    rst = 1'b0;

    // Single-flit packet from port 0.
    cyc(5'b00001, 5'b00001, 1'b1);
    chk("single_grant", 32'(grant), 32'b00001);
    chk("single_sel", 32'(sel), 32'd0);
    cyc(5'b00001, 5'b00001, 1'b1);
    chk("single_release", 32'(busy), 32'd0);
    cyc(5'b0, 5'b0, 1'b1);

    // Round robin over all ports from reset, with a bubble between grants.
    rst = 1'b1; cyc(5'b0, 5'b0, 1'b1); rst = 1'b0;
    n = 0;
    for (int c = 0; c < 12; c++) begin
      cyc(5'b11111, 5'b11111, 1'b1);
      if (c % 2 == 0) begin
        if (n < 6) order[n] = int'(sel);
        n++;
      end else begin
        chk("rr_bubble", 32'(busy), 32'd0);
      end
    end
    chk("rr_count", 32'(n), 32'd6);
    for (int i = 0; i < 6; i++) chk("rr_order", 32'(order[i]), 32'(i % 5));

    // Port 2 holds a 3-flit packet while port 1 keeps requesting.
    cyc(5'b00100, 5'b0, 1'b1);
    chk("lock_sel0", 32'(sel), 32'd2);
    cyc(5'b00110, 5'b0, 1'b1);
    chk("lock_sel1", 32'(sel), 32'd2);
    cyc(5'b00110, 5'b0, 1'b1);
    chk("lock_sel2", 32'(sel), 32'd2);
    cyc(5'b00110, 5'b00100, 1'b1);
    chk("lock_release", 32'(busy), 32'd0);
    cyc(5'b00010, 5'b0, 1'b1);
    chk("lock_next", 32'(grant), 32'b00010);
    cyc(5'b00010, 5'b00010, 1'b1);

    // Port 3 sends M tail-less flits and is forced off; port 1 is next.
    cyc(5'b01000, 5'b0, 1'b1);
    chk("force_grant", 32'(grant), 32'b01000);
    for (int i = 0; i < M - 1; i++) cyc(5'b01010, 5'b0, 1'b1);
    chk("force_pre", 32'({busy, err}), 32'b10);
    cyc(5'b01010, 5'b0, 1'b1);
    chk("force_err", 32'({busy, err}), 32'b01);
    cyc(5'b01010, 5'b0, 1'b1);
    chk("force_err_clear", 32'(err), 32'd0);
    chk("force_next", 32'(grant), 32'b00010);
    cyc(5'b00010, 5'b00010, 1'b1);

    // Port 4: backpressure stall, then the owner pauses; the counter must hold.
    cyc(5'b10000, 5'b0, 1'b1);
    cyc(5'b10000, 5'b0, 1'b1);
    for (int i = 0; i < 3; i++) cyc(5'b10000, 5'b0, 1'b0);
    chk("stall_busy", 32'(sel), 32'd4);
    for (int i = 0; i < 2; i++) cyc(5'b00001, 5'b0, 1'b1);
    chk("gap_hold", 32'(grant), 32'b10000);
    cyc(5'b10000, 5'b0, 1'b1);
    chk("resume_busy", 32'({busy, err}), 32'b10);
    cyc(5'b10000, 5'b10000, 1'b1);
    chk("resume_release", 32'({busy, err}), 32'b00);

    // Reset in the middle of a port 2 packet.
    cyc(5'b00100, 5'b0, 1'b1);
    cyc(5'b00100, 5'b0, 1'b1);
    rst = 1'b1;
    cyc(5'b11111, 5'b0, 1'b1);
    chk("mid_rst", 32'({grant, sel, busy, err}), 32'({5'b0, 3'b111, 2'b00}));
    rst = 1'b0;
    cyc(5'b11111, 5'b11111, 1'b1);
    chk("post_rst_win", 32'(grant), 32'b00001);
    cyc(5'b0, 5'b0, 1'b1);
    cyc(5'b0, 5'b0, 1'b1);

    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/output_port_arbiter.md
OUTPUT_PORT_ARBITER -- requirements
Module: output_port_arbiter

Interface
REQ-001 Parameter: LOCK_PKT, default 1, meaning 1 = hold grant until tail flit transferred, 0 = release after every transferred flit.
REQ-002 Parameter: MAX_FLITS, default 16, meaning maximum flits per grant before forced release (range 2..255).
REQ-003 Port: clk  input  1  sole clock; all state updates on rising edge.
REQ-004 Port: rst  input  1  synchronous, active-high reset.
REQ-005 Port: req  input  5  req[i] = input port i (0 local, 1 N, 2 E, 3 S, 4 W) presents a flit for this output.
REQ-006 Port: tail  input  5  tail[i] = flit currently presented by port i is the packet tail; sampled only with req[i].
REQ-007 Port: out_ready  input  1  downstream accepts a flit this cycle.
REQ-008 Port: grant  output  5  one-hot owner, or all-zero when idle.
REQ-009 Port: sel  output  3  select code for the 5:1 flit mux: 3'b000..3'b100 = owner index, 3'b111 when idle.
REQ-010 Port: out_valid  output  1  flit on mux output is valid this cycle.
REQ-011 Port: busy  output  1  arbiter is locked to an owner.
REQ-012 Port: err  output  1  one-cycle pulse on forced release at MAX_FLITS.

Function
REQ-013 The block SHALL implement a two-state FSM: IDLE, LOCKED.
REQ-014 The block SHALL keep a 3-bit last-winner pointer ptr (0..4); search order is ptr+1, ptr+2, ... modulo 5.
REQ-015 In IDLE with req != 0, the block SHALL pick the first requesting port in search order, register it as owner, and enter LOCKED on the next edge.
REQ-016 Grant latency SHALL be exactly one cycle: req sampled at edge N, grant/sel/busy valid after edge N.
REQ-017 In IDLE with req == 0, the block SHALL stay in IDLE with grant=0, sel=3'b111, busy=0.
REQ-018 In LOCKED, grant SHALL be one-hot at owner, sel = owner index, busy = 1.
REQ-019 out_valid SHALL equal LOCKED AND req[owner] (combinational from registered state and req).
REQ-020 A transfer SHALL occur in a cycle where out_valid AND out_ready are both 1.
REQ-021 A 8-bit flit counter SHALL clear on entering LOCKED and increment on each transfer.
REQ-022 Release condition: transfer AND (tail[owner] OR LOCK_PKT == 0 OR counter == MAX_FLITS-1).
REQ-023 On release, the block SHALL return to IDLE, set ptr = owner, and give one idle bubble cycle before the next grant.
REQ-024 Forced release (counter reached MAX_FLITS-1 at transfer, tail[owner] == 0, LOCK_PKT == 1) SHALL pulse err for exactly the cycle after release.
REQ-025 Requests from non-owner ports while LOCKED SHALL be ignored; no pre-emption.
REQ-026 If req[owner] drops while LOCKED, the block SHALL hold the lock with out_valid=0 (bubble) until the owner resumes.
REQ-027 If out_ready=0, the block SHALL hold state, counter, and owner unchanged.
REQ-028 sel SHALL never take values 3'b101 or 3'b110.

Reset
REQ-029 On rst=1 at a rising edge, the block SHALL enter IDLE with grant=0, sel=3'b111, out_valid=0, busy=0, err=0, counter=0, ptr=4 (port 0 highest priority first).
REQ-030 Reset SHALL take effect mid-packet, dropping the lock with no err pulse; rst SHALL dominate all other inputs.

Verification
REQ-031 Reset then req=5'b00001, tail=5'b00001, out_ready=1 -> grant=5'b00001, sel=0 one cycle later; single transfer; IDLE next; ptr=0.
REQ-032 req=5'b11111 held, every flit tail, out_ready=1 -> grant order 0,1,2,3,4,0 with one idle cycle between grants.
REQ-033 Port 2 owns, 3-flit packet (tail on 3rd), port 1 requests throughout -> sel=2 for all 3 transfers; port 1 granted only after release.
REQ-034 MAX_FLITS=4, owner sends 4 flits with tail=0 -> release after 4th transfer, err=1 for one cycle, next grant to another requester.
REQ-035 out_ready=0 for 3 cycles mid-packet, then req[owner] dropped for 2 cycles -> no state change, counter frozen, out_valid=0 during owner gap.
REQ-036 rst asserted mid-packet -> next cycle grant=0, sel=3'b111, busy=0, err=0; port 0 wins first post-reset arbitration.
